// File: rtl/phy_tx_pkg.sv
// phy_tx_pkg: shared constants and FSM encoding for the PHY TX lane scheduler
package phy_tx_pkg;
  localparam int DATA_W = 8;
  localparam int N_LANES = 4;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  typedef enum logic {ST_SYNC = 1'b0, ST_ACTIVE = 1'b1} st_e;
endpackage

// File: rtl/phy_tx_rr_arb.sv
// phy_tx_rr_arb: combinational 4-way round-robin arbiter, searching ptr+1, ptr+2, ... mod 4
//  i_req     in   4  per-lane request
//  i_ptr     in   2  last granted lane
//  o_gnt     out  4  one-hot grant
//  o_gnt_idx out  2  index of granted lane
//  o_any     out  1  some lane requested
module phy_tx_rr_arb (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [3:0] o_gnt,
  output logic [1:0] o_gnt_idx,
  output logic       o_any
);
  import phy_tx_pkg::*;
  // Scan farthest-to-nearest so the nearest requester after i_ptr is written last and wins.
  always_comb begin
    o_gnt = '0;
    o_gnt_idx = '0;
    for (int k = N_LANES; k >= 1; k--) begin
      if (i_req[i_ptr + 2'(k)]) begin
        o_gnt = '0;
        o_gnt[i_ptr + 2'(k)] = 1'b1;
        o_gnt_idx = i_ptr + 2'(k);
      end
    end
  end
  assign o_any = |i_req;
endmodule

// File: rtl/phy_tx_lane_sched.sv
// phy_tx_lane_sched: round-robin scheduler of four byte lanes onto one serializer byte stream
//  clk_4f       in   1       sole clock
//  reset        in   1       asynchronous active-low reset
//  tx_enable    in   1       1 allows ACTIVE, 0 forces SYNC
//  data_in0..3  in   DATA_W  lane bytes
//  valid0..3    in   1       lane byte valid
//  ready0..3    out  1       lane may present a byte
//  ser_ready    in   1       serializer takes a byte this cycle (slot)
//  data_out     out  DATA_W  registered byte to serializer
//  k_out        out  1       data_out is a control char
//  valid_out    out  1       data_out carries lane data
//  lane_out     out  2       lane of data_out when valid_out
//  active       out  1       FSM in ACTIVE
//  byte_cnt     out  16      lane bytes emitted, wrapping
module phy_tx_lane_sched #(
  parameter int                DATA_W      = 8,
  parameter int                SYNC_CYCLES = 4,
  parameter logic [DATA_W-1:0] COMMA       = 8'hBC,
  parameter logic [DATA_W-1:0] IDLE        = 8'h7C
) (
  input  logic              clk_4f,
  input  logic              reset,
  input  logic              tx_enable,
  input  logic [DATA_W-1:0] data_in0,
  input  logic [DATA_W-1:0] data_in1,
  input  logic [DATA_W-1:0] data_in2,
  input  logic [DATA_W-1:0] data_in3,
  input  logic              valid0,
  input  logic              valid1,
  input  logic              valid2,
  input  logic              valid3,
  output logic              ready0,
  output logic              ready1,
  output logic              ready2,
  output logic              ready3,
  input  logic              ser_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              k_out,
  output logic              valid_out,
  output logic [1:0]        lane_out,
  output logic              active,
  output logic [15:0]       byte_cnt
);
  import phy_tx_pkg::*;
  localparam int CW = SYNC_CYCLES > 1 ? $clog2(SYNC_CYCLES) : 1;
  localparam logic [CW-1:0] SYNC_LAST = CW'(SYNC_CYCLES - 1);
  st_e                r_state;
  logic [CW-1:0]      r_sync_cnt;
  logic [1:0]         r_rr;
  logic [N_LANES-1:0] r_hold_v;
  logic [DATA_W-1:0]  r_hold [N_LANES];
  logic [DATA_W-1:0]  w_din [N_LANES];
  logic [N_LANES-1:0] w_valid, w_ready, w_gnt, w_take;
  logic [1:0]         w_gnt_idx;
  logic               w_any, w_slot_grant;
  assign w_din[0] = data_in0;
  assign w_din[1] = data_in1;
  assign w_din[2] = data_in2;
  assign w_din[3] = data_in3;
  assign w_valid = {valid3, valid2, valid1, valid0};
  phy_tx_rr_arb u_arb (
    .i_req     (r_hold_v),
    .i_ptr     (r_rr),
    .o_gnt     (w_gnt),
    .o_gnt_idx (w_gnt_idx),
    .o_any     (w_any)
  );
  // A grant only happens on an ACTIVE slot that is not being torn down to SYNC.
  assign w_slot_grant = ser_ready & tx_enable & (r_state == ST_ACTIVE);
  assign w_take = w_gnt & {N_LANES{w_slot_grant}};
  assign w_ready = ~r_hold_v | w_take;
  assign {ready3, ready2, ready1, ready0} = w_ready;
  assign active = (r_state == ST_ACTIVE);
  // Lane capture ignores ser_ready; a reload on the grant edge keeps the hold full.
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_hold_v <= '0;
      for (int i = 0; i < N_LANES; i++) r_hold[i] <= '0;
    end else begin
      r_hold_v <= (r_hold_v & ~w_take) | (w_valid & w_ready);
      for (int i = 0; i < N_LANES; i++) if (w_valid[i] & w_ready[i]) r_hold[i] <= w_din[i];
    end
  end
  always_ff @(posedge clk_4f or negedge reset) begin
    if (!reset) begin
      r_state <= ST_SYNC;
      r_sync_cnt <= '0;
      r_rr <= 2'd3;
      data_out <= COMMA;
      k_out <= 1'b1;
      valid_out <= 1'b0;
      lane_out <= 2'd0;
      byte_cnt <= '0;
    end else if (ser_ready) begin
      if (r_state == ST_SYNC) begin
        data_out <= COMMA;
        k_out <= 1'b1;
        valid_out <= 1'b0;
        if (r_sync_cnt == SYNC_LAST && tx_enable) begin
          r_state <= ST_ACTIVE;
          r_sync_cnt <= '0;
        end else if (r_sync_cnt != SYNC_LAST) begin
          r_sync_cnt <= r_sync_cnt + 1'b1;
        end
      end else if (!tx_enable) begin
        r_state <= ST_SYNC;
        r_sync_cnt <= '0;
        data_out <= COMMA;
        k_out <= 1'b1;
        valid_out <= 1'b0;
      end else if (w_any) begin
        data_out <= r_hold[w_gnt_idx];
        k_out <= 1'b0;
        valid_out <= 1'b1;
        lane_out <= w_gnt_idx;
        r_rr <= w_gnt_idx;
        byte_cnt <= byte_cnt + 1'b1;
      end else begin
        data_out <= IDLE;
        k_out <= 1'b1;
        valid_out <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_phy_tx_lane_sched.sv
// tb_phy_tx_lane_sched: table vectors, directed corner sequences and random traffic against a lane-level model
module tb_phy_tx_lane_sched;
  localparam logic [7:0] COMMA = 8'hBC;
  localparam logic [7:0] IDLE = 8'h7C;
  typedef struct {
    bit          en;
    bit          sr;
    logic [3:0]  v;
    logic [31:0] d;
    logic [7:0]  x_do;
    bit          x_k;
    bit          x_v;
    logic [1:0]  x_lane;
    bit          x_act;
    logic [15:0] x_cnt;
  } vec_t;
  logic        clk_4f = 1'b0, reset = 1'b0, tx_enable = 1'b0, ser_ready = 1'b0;
  logic [7:0]  din [4];
  logic [3:0]  vin = 4'h0;
  logic        rdy0, rdy1, rdy2, rdy3;
  logic [7:0]  data_out;
  logic        k_out, valid_out, active;
  logic [1:0]  lane_out;
  logic [15:0] byte_cnt;
  int          vec_n = 0, err_n = 0;
  bit          m_hv [4];
  logic [7:0]  m_hb [4];
  bit          m_act, m_k, m_v;
  int          m_sc, m_rr;
  logic [7:0]  m_do;
  logic [1:0]  m_lane;
  logic [15:0] m_cnt;
  vec_t        tbl [11];
  always #5 clk_4f = ~clk_4f;
  phy_tx_lane_sched dut (
    .clk_4f(clk_4f), .reset(reset), .tx_enable(tx_enable),
    .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
    .valid0(vin[0]), .valid1(vin[1]), .valid2(vin[2]), .valid3(vin[3]),
    .ready0(rdy0), .ready1(rdy1), .ready2(rdy2), .ready3(rdy3),
    .ser_ready(ser_ready), .data_out(data_out), .k_out(k_out), .valid_out(valid_out),
    .lane_out(lane_out), .active(active), .byte_cnt(byte_cnt)
  );
  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      m_hv[i] = 1'b0;
      m_hb[i] = 8'h00;
    end
    m_act = 1'b0; m_sc = 0; m_rr = 3;
    m_do = COMMA; m_k = 1'b1; m_v = 1'b0; m_lane = 2'd0; m_cnt = 16'h0000;
  endtask
  // Drive one cycle at posedge+1, check ready before the edge and outputs at the next posedge+1.
  task automatic cycle(input bit en, input bit sr, input logic [3:0] v, input logic [31:0] d);
    int g = -1;
    logic [3:0] er;
    tx_enable = en; ser_ready = sr; vin = v;
    for (int i = 0; i < 4; i++) din[i] = d[8*i +: 8];
    if (sr && m_act && en)
      for (int k = 1; k <= 4; k++) if (g < 0 && m_hv[(m_rr + k) % 4]) g = (m_rr + k) % 4;
    for (int i = 0; i < 4; i++) er[i] = !m_hv[i] || g == i;
    #2;
    vec_n++;
    if ({rdy3, rdy2, rdy1, rdy0} !== er) begin
      err_n++;
      $display("FAIL ready: got %b want %b at %0t", {rdy3, rdy2, rdy1, rdy0}, er, $time);
    end
    if (sr) begin
      if (!m_act) begin
        m_do = COMMA; m_k = 1'b1; m_v = 1'b0;
        if (m_sc == 3 && en) begin
          m_act = 1'b1; m_sc = 0;
        end else if (m_sc < 3) m_sc++;
      end else if (!en) begin
        m_act = 1'b0; m_sc = 0; m_do = COMMA; m_k = 1'b1; m_v = 1'b0;
      end else if (g >= 0) begin
        m_do = m_hb[g]; m_k = 1'b0; m_v = 1'b1; m_lane = 2'(g); m_rr = g; m_cnt++;
      end else begin
        m_do = IDLE; m_k = 1'b1; m_v = 1'b0;
      end
    end
    for (int i = 0; i < 4; i++)
      if (v[i] && er[i]) begin
        m_hv[i] = 1'b1; m_hb[i] = din[i];
      end else if (g == i) m_hv[i] = 1'b0;
    @(posedge clk_4f); #1;
    vec_n++;
    if (data_out !== m_do || k_out !== m_k || valid_out !== m_v || active !== m_act ||
        byte_cnt !== m_cnt || (m_v && lane_out !== m_lane)) begin
      err_n++;
      $display("FAIL model: got d=%h k=%b v=%b l=%0d a=%b c=%h want d=%h k=%b v=%b l=%0d a=%b c=%h at %0t",
               data_out, k_out, valid_out, lane_out, active, byte_cnt,
               m_do, m_k, m_v, m_lane, m_act, m_cnt, $time);
    end
  endtask
  task automatic check(input string name, input bit ok, input int got, input int want);
    vec_n++;
    if (!ok) begin
      err_n++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask
  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    int cnt3 [4];
    int n, ns, seq, guard;
    logic [15:0] c0;
    logic [7:0] prev;
    bit sr4 [4];
    tbl[0]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'hBC, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0};
    tbl[1]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'hBC, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0};
    tbl[2]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'hBC, 1'b1, 1'b0, 2'd0, 1'b0, 16'd0};
    tbl[3]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'hBC, 1'b1, 1'b0, 2'd0, 1'b1, 16'd0};
    tbl[4]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'h7C, 1'b1, 1'b0, 2'd0, 1'b1, 16'd0};
    tbl[5]  = '{1'b1, 1'b1, 4'hF, 32'h43322110, 8'h7C, 1'b1, 1'b0, 2'd0, 1'b1, 16'd0};
    tbl[6]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'h10, 1'b0, 1'b1, 2'd0, 1'b1, 16'd1};
    tbl[7]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'h21, 1'b0, 1'b1, 2'd1, 1'b1, 16'd2};
    tbl[8]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'h32, 1'b0, 1'b1, 2'd2, 1'b1, 16'd3};
    tbl[9]  = '{1'b1, 1'b1, 4'h0, 32'h0,        8'h43, 1'b0, 1'b1, 2'd3, 1'b1, 16'd4};
    tbl[10] = '{1'b1, 1'b1, 4'h0, 32'h0,        8'h7C, 1'b1, 1'b0, 2'd3, 1'b1, 16'd4};
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
    model_reset();
    #12;
    check("reset_state", data_out === COMMA && k_out === 1'b1 && valid_out === 1'b0 && lane_out === 2'd0 &&
          active === 1'b0 && byte_cnt === 16'h0 && {rdy3, rdy2, rdy1, rdy0} === 4'hF,
          int'({data_out, k_out, valid_out, active}), int'({COMMA, 3'b100}));
    @(posedge clk_4f); #1;
    reset = 1'b1;
    for (int r = 0; r < 11; r++) begin
      cycle(tbl[r].en, tbl[r].sr, tbl[r].v, tbl[r].d);
      vec_n++;
      if (data_out !== tbl[r].x_do || k_out !== tbl[r].x_k || valid_out !== tbl[r].x_v ||
          active !== tbl[r].x_act || byte_cnt !== tbl[r].x_cnt || (tbl[r].x_v && lane_out !== tbl[r].x_lane)) begin
        err_n++;
        $display("FAIL tbl[%0d]: got d=%h k=%b v=%b l=%0d a=%b c=%h want d=%h k=%b v=%b l=%0d a=%b c=%h", r,
                 data_out, k_out, valid_out, lane_out, active, byte_cnt,
                 tbl[r].x_do, tbl[r].x_k, tbl[r].x_v, tbl[r].x_lane, tbl[r].x_act, tbl[r].x_cnt);
      end
    end
    for (int i = 0; i < 4; i++) cnt3[i] = 0;
    cycle(1'b1, 1'b1, 4'hF, $urandom);
    for (int s = 0; s < 40; s++) begin
      cycle(1'b1, 1'b1, 4'hF, $urandom);
      check("fair_lane", valid_out === 1'b1 && lane_out === 2'(s % 4), int'({valid_out, lane_out}), 4 + s % 4);
      if (valid_out) cnt3[lane_out]++;
    end
    for (int i = 0; i < 4; i++) check("fair_count", cnt3[i] == 10, cnt3[i], 10);
    for (int s = 0; s < 6; s++) cycle(1'b1, 1'b1, 4'h0, 32'h0);
    sr4 = '{1'b1, 1'b0, 1'b0, 1'b1};
    cycle(1'b1, 1'b1, 4'b0100, 32'h00550000);
    c0 = byte_cnt;
    n = 0;
    for (int j = 0; j < 4; j++) begin
      prev = data_out;
      cycle(1'b1, sr4[j], 4'h0, 32'h0);
      if (sr4[j] && valid_out && lane_out == 2'd2) n++;
      if (!sr4[j]) check("stall_frozen", data_out === prev, int'(data_out), int'(prev));
    end
    check("stall_once", n == 1, n, 1);
    check("stall_cnt", byte_cnt === c0 + 16'd1, int'(byte_cnt), int'(c0 + 16'd1));
    cycle(1'b1, 1'b1, 4'b0001, 32'h66);
    cycle(1'b1, 1'b1, 4'h0, 32'h0);
    cycle(1'b0, 1'b1, 4'b1010, 32'h88007700);
    check("dis_active", active === 1'b0, int'(active), 0);
    for (int s = 0; s < 5; s++) begin
      cycle(1'b0, 1'b1, 4'h0, 32'h0);
      check("dis_comma", valid_out === 1'b0 && data_out === COMMA && active === 1'b0,
            int'({data_out, valid_out, active}), int'({COMMA, 2'b00}));
    end
    ns = 0;
    seq = 0;
    for (int s = 0; s < 20 && ns < 2; s++) begin
      cycle(1'b1, 1'b1, 4'h0, 32'h0);
      if (valid_out) begin
        seq = seq * 4 + int'(lane_out);
        ns++;
      end
    end
    check("reenable_order", ns == 2 && seq == 7, seq, 7);
    for (int s = 0; s < 400; s++)
      cycle($urandom_range(9) != 0, $urandom_range(3) != 0, 4'($urandom), $urandom);
    for (int s = 0; s < 12; s++) cycle(1'b1, 1'b1, 4'h0, 32'h0);
    guard = 0;
    while (m_cnt != 16'hFFFE && guard < 70000) begin
      cycle(1'b1, 1'b1, {3'b000, (32'(m_cnt) + 32'(m_hv[0])) < 32'hFFFE}, $urandom);
      guard++;
    end
    check("preload", byte_cnt === 16'hFFFE, int'(byte_cnt), 16'hFFFE);
    cycle(1'b1, 1'b1, 4'b0111, $urandom);
    for (int s = 0; s < 3; s++) cycle(1'b1, 1'b1, 4'h0, 32'h0);
    check("cnt_wrap", byte_cnt === 16'h0001, int'(byte_cnt), 1);
    cycle(1'b1, 1'b1, 4'hF, $urandom);
    cycle(1'b1, 1'b1, 4'h0, 32'h0);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset", data_out === COMMA && k_out === 1'b1 && valid_out === 1'b0 && lane_out === 2'd0 &&
          active === 1'b0 && byte_cnt === 16'h0 && {rdy3, rdy2, rdy1, rdy0} === 4'hF,
          int'({data_out, k_out, valid_out, active, byte_cnt}), int'({COMMA, 3'b100, 16'h0}));
    model_reset();
    repeat (3) @(posedge clk_4f);
    #1;
    reset = 1'b1;
    for (int s = 0; s < 8; s++) cycle(1'b1, 1'b1, 4'h0, 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_n, err_n);
    $finish;
  end
endmodule
